clock_ctrl_04: RTL and testbench

CLOCK_CTRL_04 -- requirements
Module: clock_ctrl_04

---
 rtl/clock_ctrl_04.sv | 131 +++++++++++++
 tb/tb_clock_ctrl_04.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl_04.sv
// Settable BCD time-of-day clock with a RUN / SET_HOUR / SET_MIN mode cycle.
// Keys are pre-debounced levels; each rising edge is a single event.
module clock_ctrl_04 #(
   parameter int unsigned HOUR_MOD = 24
) (
   input  logic       clk_04,
   input  logic       rst_04,
   input  logic       tick_04,
   input  logic       key_mode_04,
   input  logic       key_inc_04,
   output logic [7:0] sec_04,
   output logic [7:0] min_04,
   output logic [7:0] hour_04,
   output logic [1:0] state_04,
   output logic       day_co_04
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      BAD      = 2'b11
   } state_t;

   // Only 24 and 12 are meaningful; anything else behaves as 24.
   localparam logic [7:0] HOUR_LAST = (HOUR_MOD == 12) ? 8'h11 : 8'h23;
   localparam logic [7:0] MS_LAST   = 8'h59;

   state_t state;
   state_t next_state;
   logic   mode_q;
   logic   inc_q;
   logic   mode_ev;
   logic   inc_ev;
   logic   do_tick;
   logic   inc_hour;
   logic   inc_min;
   logic   clr_sec;

   // BCD increment of a two-digit value, wrapping to 00 after 'last'.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
      logic [7:0] r;
      if (v == last)
         r = '0;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   assign mode_ev = key_mode_04 & ~mode_q;
   assign inc_ev  = key_inc_04 & ~inc_q;

   // Key history flops; reset high so a key held through reset is not an event.
   always_ff @(posedge clk_04 or negedge rst_04) begin
      if (!rst_04) begin
         mode_q <= 1'b1;
         inc_q  <= 1'b1;
      end else begin
         mode_q <= key_mode_04;
         inc_q  <= key_inc_04;
      end
   end

   // Mode state register.
   always_ff @(posedge clk_04 or negedge rst_04) begin
      if (!rst_04)
         state <= RUN;
      else
         state <= next_state;
   end

   // Mode sequencing on key_mode events; the unused encoding falls back to RUN.
   always_comb begin
      next_state = state;
      case (state)
         RUN:      if (mode_ev) next_state = SET_HOUR;
         SET_HOUR: if (mode_ev) next_state = SET_MIN;
         SET_MIN:  if (mode_ev) next_state = RUN;
         default:  next_state = RUN;
      endcase
   end

   // Counter actions; a mode event on the same edge pre-empts ticks and incs.
   always_comb begin
      do_tick  = 1'b0;
      inc_hour = 1'b0;
      inc_min  = 1'b0;
      clr_sec  = 1'b0;
      case (state)
         RUN:      do_tick  = tick_04 & ~mode_ev;
         SET_HOUR: inc_hour = inc_ev & ~mode_ev;
         SET_MIN: begin
            inc_min = inc_ev & ~mode_ev;
            clr_sec = mode_ev;
         end
         default: ;
      endcase
   end

   // Time registers and the registered full-day carry pulse.
   always_ff @(posedge clk_04 or negedge rst_04) begin
      if (!rst_04) begin
         sec_04    <= '0;
         min_04    <= '0;
         hour_04   <= '0;
         day_co_04 <= 1'b0;
      end else begin
         day_co_04 <= do_tick && (sec_04 == MS_LAST) && (min_04 == MS_LAST)
                      && (hour_04 == HOUR_LAST);
         if (clr_sec) begin
            sec_04 <= '0;
         end else if (do_tick) begin
            sec_04 <= bcd_inc(sec_04, MS_LAST);
            if (sec_04 == MS_LAST) begin
               min_04 <= bcd_inc(min_04, MS_LAST);
               if (min_04 == MS_LAST)
                  hour_04 <= bcd_inc(hour_04, HOUR_LAST);
            end
         end else if (inc_hour) begin
            hour_04 <= bcd_inc(hour_04, HOUR_LAST);
         end else if (inc_min) begin
            min_04 <= bcd_inc(min_04, MS_LAST);
         end
      end
   end

   assign state_04 = state;

endmodule

// File: tb/tb_clock_ctrl_04.sv
module tb_clock_ctrl_04;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       key_mode = 1'b0;
   logic       key_inc = 1'b0;
   logic [7:0] sec_a, min_a, hour_a;
   logic [1:0] state_a;
   logic       day_co_a;
   logic [7:0] sec_b, min_b, hour_b;
   logic [1:0] state_b;
   logic       day_co_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   clock_ctrl_04 #(.HOUR_MOD(24)) dut24 (
      .clk_04(clk), .rst_04(rst), .tick_04(tick),
      .key_mode_04(key_mode), .key_inc_04(key_inc),
      .sec_04(sec_a), .min_04(min_a), .hour_04(hour_a),
      .state_04(state_a), .day_co_04(day_co_a)
   );

   clock_ctrl_04 #(.HOUR_MOD(12)) dut12 (
      .clk_04(clk), .rst_04(rst), .tick_04(tick),
      .key_mode_04(key_mode), .key_inc_04(key_inc),
      .sec_04(sec_b), .min_04(min_b), .hour_04(hour_b),
      .state_04(state_b), .day_co_04(day_co_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_mode();
      key_mode = 1'b1;
      step();
      key_mode = 1'b0;
      step();
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         key_inc = 1'b1;
         step();
         key_inc = 1'b0;
         step();
      end
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) step();
      tick = 1'b0;
   endtask

   initial begin
      // Reset applies before any clock edge
      #2;
      check("rst_time", {sec_a, min_a, hour_a}, 24'h000000);
      check("rst_state", state_a, 2'b00);
      check("rst_dayco", day_co_a, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();

      // Inc in RUN is discarded
      press_inc(1);
      check("run_inc_ignored", {state_a, hour_a, min_a}, {2'b00, 16'h0000});

      // Hour setting and modulus wrap
      press_mode();
      check("set_hour_state", state_a, 2'b01);
      press_inc(12);
      check("h24_12press", hour_a, 8'h12);
      check("h12_12press", hour_b, 8'h00);
      press_inc(13);
      check("h24_25press", hour_a, 8'h01);
      check("h12_25press", hour_b, 8'h01);
      check("min_untouched", min_a, 8'h00);
      press_inc(22);
      check("h24_23", hour_a, 8'h23);
      check("h12_11", hour_b, 8'h11);

      // Minute setting
      press_mode();
      check("set_min_state", state_a, 2'b10);
      press_inc(59);
      check("min59", {hour_a, min_a}, 16'h2359);

      // Tick frozen in SET_MIN, then minute wrap leaves hour alone
      ticks(1);
      check("setmin_tick_frozen", {hour_a, min_a, sec_a}, 24'h235900);
      press_inc(1);
      check("min_wrap", {hour_a, min_a, day_co_a}, {16'h2300, 1'b0});
      press_inc(59);

      // Back to RUN, full-day rollover
      press_mode();
      check("back_run", {state_a, sec_a}, {2'b00, 8'h00});
      ticks(59);
      check("t59", {hour_a, min_a, sec_a}, 24'h235959);
      check("t59_12", {hour_b, min_b, sec_b}, 24'h115959);
      check("t59_dayco", day_co_a, 1'b0);
      ticks(1);
      check("t60", {hour_a, min_a, sec_a}, 24'h000000);
      check("t60_dayco", day_co_a, 1'b1);
      check("t60_12", {hour_b, min_b, sec_b, day_co_b}, {24'h000000, 1'b1});
      step();
      check("dayco_one_cycle", {day_co_a, day_co_b}, 2'b00);

      // Set 12:34 and count to 12:34:56
      press_mode();
      press_inc(12);
      press_mode();
      press_inc(34);
      press_mode();
      ticks(56);
      check("t123456", {hour_a, min_a, sec_a}, 24'h123456);

      // Async reset mid-count, keys held across release
      tick = 1'b1;
      #1;
      rst = 1'b0;
      #2;
      check("async_rst", {hour_a, min_a, sec_a, state_a, day_co_a}, {24'h000000, 2'b00, 1'b0});
      tick = 1'b0;
      key_mode = 1'b1;
      key_inc = 1'b1;
      step();
      rst = 1'b1;
      step();
      step();
      check("held_keys_no_event", {state_a, hour_a}, {2'b00, 8'h00});
      key_mode = 1'b0;
      key_inc = 1'b0;
      step();

      // Simultaneous mode and inc: mode wins
      key_mode = 1'b1;
      key_inc = 1'b1;
      step();
      check("mode_inc_same", {state_a, hour_a}, {2'b01, 8'h00});
      key_mode = 1'b0;
      key_inc = 1'b0;
      step();

      // Long hold counts once
      key_inc = 1'b1;
      repeat (100) step();
      key_inc = 1'b0;
      step();
      check("long_hold", hour_a, 8'h01);

      // Set 10:15:30
      press_inc(9);
      press_mode();
      press_inc(15);
      press_mode();
      ticks(30);
      check("t101530", {state_a, hour_a, min_a, sec_a}, {2'b00, 24'h101530});

      // Mode coinciding with tick leaves time frozen
      key_mode = 1'b1;
      tick = 1'b1;
      step();
      key_mode = 1'b0;
      tick = 1'b0;
      check("mode_tick", {state_a, hour_a, min_a, sec_a}, {2'b01, 24'h101530});
      step();

      // SET_MIN->RUN with tick clears seconds
      press_mode();
      key_mode = 1'b1;
      tick = 1'b1;
      step();
      key_mode = 1'b0;
      tick = 1'b0;
      check("exit_tick", {state_a, hour_a, min_a, sec_a}, {2'b00, 24'h101500});
      ticks(1);
      check("resume", sec_a, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
